se_prog_loader: RTL

- Upstream feeder of se_InstrMem_top. It drives that block's loadData_i, loadAddr_i and wrEn_i.
- Accepts a framed byte stream over a valid/ready handshake. The frame is a 16-bit word count followed by little-endian 32-bit instructions.
- Writes each instruction as a single-cycle write strobe at consecutive word addresses.
- On completion, signals done so the core releases fetch and starts at bootPc_o.

---
 rtl/se_loader_pkg.sv | 29 ++
 rtl/se_byte_assembler.sv | 40 ++++
 rtl/se_prog_loader.sv | 136 +++++++++++++
 3 files changed

// File: rtl/se_loader_pkg.sv
// ---------------------------------------------------------------------------
// se_loader_pkg : shared types and constants for the program loader
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package se_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_LO = 3'd1,
      S_LEN_HI = 3'd2,
      S_DATA   = 3'd3,
      S_WRITE  = 3'd4,
      S_DONE   = 3'd5,
      S_ERROR  = 3'd6
   } state_t;

   localparam int LEN_BYTES      = 2;
   localparam int BYTES_PER_WORD = 4;

   // Counter must be able to hold MEM_WORDS itself, hence the extra bit.
   function automatic int cnt_width(input int mem_words);
      return $clog2(mem_words) + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/se_byte_assembler.sv
// ---------------------------------------------------------------------------
// se_byte_assembler : little-endian 4-byte shift register with byte index
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module se_byte_assembler
   import se_loader_pkg::*;
(
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          shift_en,
   input  logic                          clear,
   input  logic [7:0]                    byte_in,
   output logic [8*BYTES_PER_WORD-1:0]   word,
   output logic                          word_full
);

   logic [1:0] idx;

   // Shifting right from the top lands the first byte in bits [7:0].
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         word <= '0;
         idx  <= '0;
      end else if (clear) begin
         word <= '0;
         idx  <= '0;
      end else if (shift_en) begin
         word <= {byte_in, word[8*BYTES_PER_WORD-1:8]};
         idx  <= idx + 2'd1;
      end
   end

   // High on the shift that completes the word; idx wraps to 0 with it.
   assign word_full = shift_en && (idx == 2'(BYTES_PER_WORD - 1));

endmodule

`default_nettype wire

// File: rtl/se_prog_loader.sv
// ---------------------------------------------------------------------------
// se_prog_loader : framed byte stream to instruction-memory write strobes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module se_prog_loader
   import se_loader_pkg::*;
#(
   parameter int unsigned         ADDR_W    = 64,
   parameter int unsigned         DATA_W    = 32,
   parameter int unsigned         MEM_WORDS = 1024,
   parameter logic [ADDR_W-1:0]   BASE_ADDR = '0,
   localparam int unsigned        CNT_W     = cnt_width(MEM_WORDS)
)(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic [7:0]          byte_i,
   input  logic                byteValid_i,
   output logic                byteReady_o,
   output logic [DATA_W-1:0]   loadData_o,
   output logic [ADDR_W-1:0]   loadAddr_o,
   output logic                wrEn_o,
   output logic                busy_o,
   output logic                done_o,
   output logic                err_o,
   output logic [CNT_W-1:0]    wordCnt_o,
   output logic [ADDR_W-1:0]   bootPc_o
);

   if (DATA_W != 32) begin : g_bad_data_w
      $error("se_prog_loader: DATA_W must be 32");
   end

   state_t                      state, state_nxt;
   logic [8*LEN_BYTES-1:0]      len_q;
   logic [CNT_W-1:0]            cnt;
   logic [CNT_W-1:0]            cnt_inc;
   logic [ADDR_W-1:0]           addr_q;
   logic [DATA_W-1:0]           data_hold;
   logic                        ready_q;
   logic                        xfer;
   logic                        start_ok;
   logic [8*LEN_BYTES-1:0]      len_full;
   logic                        len_bad;
   logic                        last_word;
   logic                        asm_shift;
   logic                        asm_clear;
   logic [DATA_W-1:0]           asm_word;
   logic                        asm_full;

   se_byte_assembler u_asm (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .shift_en  (asm_shift),
      .clear     (asm_clear),
      .byte_in   (byte_i),
      .word      (asm_word),
      .word_full (asm_full)
   );

   assign xfer      = byteValid_i && byteReady_o;
   assign start_ok  = start_i && (state inside {S_IDLE, S_DONE, S_ERROR});
   assign len_full  = {byte_i, len_q[7:0]};
   assign len_bad   = (len_full == '0) || (32'(len_full) > 32'(MEM_WORDS));
   assign cnt_inc   = cnt + CNT_W'(1);
   assign last_word = (32'(cnt_inc) == 32'(len_q));

   always_comb begin
      state_nxt = state;
      asm_shift = 1'b0;
      asm_clear = 1'b0;
      case (state)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start_i) begin
               state_nxt = S_LEN_LO;
               asm_clear = 1'b1;
            end
         end
         S_LEN_LO: if (xfer) state_nxt = S_LEN_HI;
         S_LEN_HI: begin
            if (xfer) begin
               state_nxt = len_bad ? S_ERROR : S_DATA;
               asm_clear = 1'b1;
            end
         end
         S_DATA: begin
            if (xfer) begin
               asm_shift = 1'b1;
               if (asm_full) state_nxt = S_WRITE;
            end
         end
         S_WRITE: state_nxt = last_word ? S_DONE : S_DATA;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= S_IDLE;
         ready_q   <= 1'b0;
         len_q     <= '0;
         cnt       <= '0;
         addr_q    <= BASE_ADDR;
         data_hold <= '0;
      end else begin
         state   <= state_nxt;
         ready_q <= state_nxt inside {S_LEN_LO, S_LEN_HI, S_DATA};
         if (state == S_LEN_LO && xfer) len_q[7:0]  <= byte_i;
         if (state == S_LEN_HI && xfer) len_q[15:8] <= byte_i;
         if (start_ok)
            cnt <= '0;
         else if (state == S_WRITE)
            cnt <= cnt_inc;
         // Address is fixed on the edge that completes the word.
         if (state == S_DATA && xfer && asm_full)
            addr_q <= BASE_ADDR + (ADDR_W'(cnt) * ADDR_W'(BYTES_PER_WORD));
         if (state == S_WRITE)
            data_hold <= asm_word;
      end
   end

   assign byteReady_o = ready_q;
   assign wrEn_o      = (state == S_WRITE);
   assign loadData_o  = wrEn_o ? asm_word : data_hold;
   assign loadAddr_o  = addr_q;
   assign busy_o      = state inside {S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE};
   assign done_o      = (state == S_DONE);
   assign err_o       = (state == S_ERROR);
   assign wordCnt_o   = cnt;
   assign bootPc_o    = BASE_ADDR;

endmodule

`default_nettype wire
